// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one operand bit per clock.
// Three-state FSM (IDLE -> SHIFT -> DONE); result register only updates on completion.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_scratch;
  logic [WIDTH-1:0] r_operand;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_bcd;
  logic             r_busy;
  logic             r_done;
  logic [SW-1:0]    w_scratch_adj;
  logic [SW-1:0]    w_scratch_shift;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Add 3 to every nibble >= 5, the top nibble included.
  function automatic logic [SW-1:0] f_add3(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign w_last          = (r_cnt == CW'(WIDTH - 1));
  assign w_scratch_adj   = f_add3(r_scratch);
  assign w_scratch_shift = {w_scratch_adj[SW-2:0], r_operand[WIDTH-1]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they register alongside it.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_SHIFT: w_busy_nxt = 1'b1;
      S_DONE:  w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_scratch <= {SW{1'b0}};
      r_operand <= {WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_bcd     <= {SW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_operand <= i_bin;
            r_scratch <= {SW{1'b0}};
            r_cnt     <= {CW{1'b0}};
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scratch_shift;
          r_operand <= {r_operand[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt + CW'(1);
          // Publish only the fully shifted value so o_bcd never shows partials.
          if (w_last) begin
            r_bcd <= w_scratch_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: timing, back-to-back, ignored starts,
// mid-conversion reset and a full 0..255 sweep.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_checks;
  int n_fail;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .i_clock (clk),
    .i_reset (reset),
    .i_start (start),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with b, optionally re-pulse start at cycle pulse_at, then watch 12 cycles.
  task automatic convert(input logic [7:0] b, input int pulse_at, input logic [7:0] pulse_bin,
                         output int busy_cyc, output int done_cnt, output int latency,
                         output logic [11:0] result, output logic partial_bad,
                         output logic hold_bad);
    logic [11:0] prev;
    prev        = bcd;
    busy_cyc    = 0;
    done_cnt    = 0;
    latency     = -1;
    result      = 12'h000;
    partial_bad = 1'b0;
    hold_bad    = 1'b0;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    bin   = ~b;
    for (int n = 1; n <= 12; n++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (latency < 0) begin
          latency = n;
          result  = bcd;
        end
      end else if (latency < 0) begin
        if (bcd !== prev) partial_bad = 1'b1;
      end else begin
        if (bcd !== result) hold_bad = 1'b1;
      end
      if (n == pulse_at) begin
        start = 1'b1;
        bin   = pulse_bin;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    bin   = 8'd123;
    tick();
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", bcd); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int bc, dc, lat;
    logic [11:0] r;
    logic pb, hb;
    convert(8'd0, 0, 8'd0, bc, dc, lat, r, pb, hb);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL zero_latency got %0d want 9", lat); end
    n_checks++;
    if (r !== 12'h000) begin n_fail++; $display("FAIL zero_bcd got %h want 000", r); end
  endtask

  task automatic test_max();
    int bc, dc, lat;
    logic [11:0] r;
    logic pb, hb;
    convert(8'd255, 0, 8'd0, bc, dc, lat, r, pb, hb);
    n_checks++;
    if (bc !== 8) begin n_fail++; $display("FAIL max_busy_cycles got %0d want 8", bc); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL max_done_count got %0d want 1", dc); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL max_latency got %0d want 9", lat); end
    n_checks++;
    if (r !== 12'h255) begin n_fail++; $display("FAIL max_bcd got %h want 255", r); end
    n_checks++;
    if (pb !== 1'b0) begin n_fail++; $display("FAIL max_partial got %b want 0", pb); end
    n_checks++;
    if (hb !== 1'b0) begin n_fail++; $display("FAIL max_hold got %b want 0", hb); end
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1;
    bin   = 8'd99;
    tick();
    start = 1'b0;
    bin   = 8'd0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 9) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 9", n); end
    n_checks++;
    if (bcd !== 12'h099) begin n_fail++; $display("FAIL b2b_first_bcd got %h want 099", bcd); end
    // Start raised during DONE must be ignored; held into IDLE it is accepted.
    start = 1'b1;
    bin   = 8'd100;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start_ignored busy got %b want 0", busy); end
    tick();
    start = 1'b0;
    bin   = 8'd0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept busy got %b want 1", busy); end
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 9) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 9", n); end
    n_checks++;
    if (bcd !== 12'h100) begin n_fail++; $display("FAIL b2b_second_bcd got %h want 100", bcd); end
    tick();
    tick();
  endtask

  task automatic test_start_while_busy();
    int bc, dc, lat;
    logic [11:0] r;
    logic pb, hb;
    convert(8'd10, 3, 8'd77, bc, dc, lat, r, pb, hb);
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", dc); end
    n_checks++;
    if (r !== 12'h010) begin n_fail++; $display("FAIL busy_start_bcd got %h want 010", r); end
    n_checks++;
    if (bcd !== 12'h010) begin n_fail++; $display("FAIL busy_start_bcd_after got %h want 010", bcd); end
  endtask

  task automatic test_reset_mid_shift();
    int bc, dc, lat, dseen;
    logic [11:0] r;
    logic pb, hb;
    start = 1'b1;
    bin   = 8'd200;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++;
    if (bcd !== 12'h000) begin n_fail++; $display("FAIL midreset_bcd got %h want 000", bcd); end
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dseen++;
      tick();
    end
    n_checks++;
    if (dseen !== 0) begin n_fail++; $display("FAIL midreset_no_done got %0d want 0", dseen); end
    convert(8'd42, 0, 8'd0, bc, dc, lat, r, pb, hb);
    n_checks++;
    if (r !== 12'h042) begin n_fail++; $display("FAIL midreset_restart_bcd got %h want 042", r); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL midreset_restart_latency got %0d want 9", lat); end
  endtask

  task automatic test_sweep();
    int bc, dc, lat;
    logic [11:0] r;
    logic [11:0] exp_v;
    logic pb, hb;
    int v;
    for (int b = 0; b < 256; b++) begin
      v = b;
      exp_v = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(8'(b), 0, 8'd0, bc, dc, lat, r, pb, hb);
      n_checks++;
      if (r !== exp_v || dc !== 1) begin
        n_fail++;
        $display("FAIL sweep bin=%0d got %h (dones %0d) want %h (dones 1)", b, r, dc, exp_v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    bin      = 8'd0;
    #1;
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_shift();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
